rst_status_table_spec: RTL and testbench

//  Parametrised register status table (scoreboard) for the tensor-core dispatch stage. Tracks per-register

---
 rtl/rst_status_table_spec.sv | 171 +++++++++++++++++
 tb/tb_rst_status_table_spec.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rst_status_table_spec.sv
// Register status table: per-register busy/tag/branch-mask scoreboard with tag-checked writeback and nested speculation.
// Latency: lookups are combinational with same-cycle writeback forwarding; state and summaries update 1 cycle after inputs.
// Backpressure: none; dispatch and writeback are single-cycle pulses and always accepted (flushed dispatch is dropped).
module rst_status_table_spec #(
    parameter int NUM_REGS   = 32,
    parameter int TAG_W      = 2,
    parameter int NUM_WB     = 2,
    parameter int NUM_RD     = 2,
    parameter int SPEC_DEPTH = 4,
    parameter int ZERO_REG   = 1,
    localparam int SEL_W     = $clog2(NUM_REGS),
    localparam int CNT_W     = $clog2(NUM_REGS) + 1
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic                     di_write,
    input  logic [SEL_W-1:0]         di_sel,
    input  logic [TAG_W-1:0]         di_tag,
    input  logic [SPEC_DEPTH-1:0]    di_spec_mask,
    input  logic [NUM_WB-1:0]        wb_write,
    input  logic [NUM_WB*SEL_W-1:0]  wb_sel,
    input  logic [NUM_WB*TAG_W-1:0]  wb_tag,
    input  logic [SPEC_DEPTH-1:0]    resolve_mask,
    input  logic [SPEC_DEPTH-1:0]    flush_mask,
    input  logic [NUM_RD*SEL_W-1:0]  rd_sel,
    output logic [NUM_RD-1:0]        rd_busy,
    output logic [NUM_RD*TAG_W-1:0]  rd_tag,
    output logic [NUM_REGS-1:0]      busy_vec,
    output logic                     spec_any,
    output logic [CNT_W-1:0]         busy_count
);

    // One scoreboard entry; mask is kept at zero whenever busy is clear.
    typedef struct packed {
        logic                  busy;
        logic [TAG_W-1:0]      tag;
        logic [SPEC_DEPTH-1:0] mask;
    } entry_t;

    entry_t                ent_q [NUM_REGS];
    entry_t                ent_n [NUM_REGS];
    logic [NUM_REGS-1:0]   wb_clr;
    logic [NUM_REGS-1:0]   flush_clr;
    logic [SPEC_DEPTH-1:0] eff_resolve;
    logic                  di_ok;
    logic                  waw_viol;
    logic [CNT_W-1:0]      busy_count_n;
    logic                  spec_any_n;
    logic [CNT_W-1:0]      busy_count_q;
    logic                  spec_any_q;
    logic [SEL_W-1:0]      lk_sel;
    logic                  lk_hit;
    logic                  lk_busy;

    // A level both resolved and flushed counts as a flush, so strip it from the resolve set.
    assign eff_resolve = resolve_mask & ~flush_mask;

    // Dispatch is accepted unless it targets the hardwired zero register or depends on a level being flushed now.
    assign di_ok = di_write
                 && !((ZERO_REG != 0) && (di_sel == '0))
                 && ((di_spec_mask & flush_mask) == '0);

    // Writeback clears an entry only when it is busy and the tag matches the current producer.
    always_comb begin
        wb_clr = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            for (int i = 0; i < NUM_WB; i++) begin
                if (wb_write[i]
                    && (wb_sel[i*SEL_W +: SEL_W] == SEL_W'(r))
                    && (wb_tag[i*TAG_W +: TAG_W] == ent_q[r].tag)
                    && ent_q[r].busy) begin
                    wb_clr[r] = 1'b1;
                end
            end
        end
    end

    // Flush kills any busy entry whose dependence mask intersects a mispredicted level.
    always_comb begin
        flush_clr = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            flush_clr[r] = ent_q[r].busy && ((ent_q[r].mask & flush_mask) != '0);
        end
    end

    // Next-state per entry: resolve, then writeback, then flush, then dispatch (later wins).
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            ent_n[r]      = ent_q[r];
            ent_n[r].mask = ent_q[r].mask & ~eff_resolve;
            if (wb_clr[r] || flush_clr[r]) begin
                ent_n[r].busy = 1'b0;
                ent_n[r].mask = '0;
            end
            if (di_ok && (di_sel == SEL_W'(r))) begin
                ent_n[r].busy = 1'b1;
                ent_n[r].tag  = di_tag;
                ent_n[r].mask = di_spec_mask & ~eff_resolve;
            end
        end
    end

    // Summary values computed from next state so the registered outputs track the entries exactly.
    always_comb begin
        busy_count_n = '0;
        spec_any_n   = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
            busy_count_n = busy_count_n + CNT_W'(ent_n[r].busy);
            if (ent_n[r].busy && (ent_n[r].mask != '0)) begin
                spec_any_n = 1'b1;
            end
        end
    end

    // Operand lookup against current state, forwarding any matching writeback seen this cycle.
    always_comb begin
        rd_busy = '0;
        rd_tag  = '0;
        lk_sel  = '0;
        lk_hit  = 1'b0;
        lk_busy = 1'b0;
        for (int j = 0; j < NUM_RD; j++) begin
            lk_sel = rd_sel[j*SEL_W +: SEL_W];
            lk_hit = 1'b0;
            for (int i = 0; i < NUM_WB; i++) begin
                if (wb_write[i]
                    && (wb_sel[i*SEL_W +: SEL_W] == lk_sel)
                    && (wb_tag[i*TAG_W +: TAG_W] == ent_q[lk_sel].tag)) begin
                    lk_hit = 1'b1;
                end
            end
            lk_busy = ent_q[lk_sel].busy && !lk_hit && !((ZERO_REG != 0) && (lk_sel == '0));
            rd_busy[j] = lk_busy;
            rd_tag[j*TAG_W +: TAG_W] = lk_busy ? ent_q[lk_sel].tag : '0;
        end
    end

    // Scoreboard state and registered summaries; reset discards everything immediately.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                ent_q[r] <= '0;
            end
            busy_count_q <= '0;
            spec_any_q   <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                ent_q[r] <= ent_n[r];
            end
            busy_count_q <= busy_count_n;
            spec_any_q   <= spec_any_n;
        end
    end

    // Expose the per-register busy bits straight from state.
    always_comb begin
        busy_vec = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            busy_vec[r] = ent_q[r].busy;
        end
    end

    assign busy_count = busy_count_q;
    assign spec_any   = spec_any_q;

    // Upstream must not dispatch onto a live producer unless that producer retires in the same cycle.
    assign waw_viol = di_ok && ent_q[di_sel].busy && !wb_clr[di_sel] && !flush_clr[di_sel];

    waw_check: assert property (@(posedge CLK) disable iff (!nRST) !waw_viol);

endmodule

// File: tb/tb_rst_status_table_spec.sv
// Directed bench for the register status table with a cycle-stamped scoreboard.
// Stimulus pushes expectations tagged with the cycle they must hold; a negedge monitor pops and compares.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_rst_status_table_spec;

    localparam int SEL_W = 5;
    localparam int TAG_W = 2;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        di_write;
    logic [4:0]  di_sel;
    logic [1:0]  di_tag;
    logic [3:0]  di_spec_mask;
    logic [1:0]  wb_write;
    logic [9:0]  wb_sel;
    logic [3:0]  wb_tag;
    logic [3:0]  resolve_mask;
    logic [3:0]  flush_mask;
    logic [9:0]  rd_sel;
    logic [1:0]  rd_busy;
    logic [3:0]  rd_tag;
    logic [31:0] busy_vec;
    logic        spec_any;
    logic [5:0]  busy_count;

    rst_status_table_spec dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .di_write     (di_write),
        .di_sel       (di_sel),
        .di_tag       (di_tag),
        .di_spec_mask (di_spec_mask),
        .wb_write     (wb_write),
        .wb_sel       (wb_sel),
        .wb_tag       (wb_tag),
        .resolve_mask (resolve_mask),
        .flush_mask   (flush_mask),
        .rd_sel       (rd_sel),
        .rd_busy      (rd_busy),
        .rd_tag       (rd_tag),
        .busy_vec     (busy_vec),
        .spec_any     (spec_any),
        .busy_count   (busy_count)
    );

    always #5 CLK = ~CLK;

    // Expectation kinds
    localparam int K_VEC = 0, K_CNT = 1, K_SPEC = 2, K_RBUSY = 3, K_RTAG = 4;

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            K_VEC:   return "busy_vec";
            K_CNT:   return "busy_count";
            K_SPEC:  return "spec_any";
            K_RBUSY: return "rd_busy";
            default: return "rd_tag";
        endcase
    endfunction

    function automatic logic [31:0] observe(input int k);
        case (k)
            K_VEC:   return busy_vec;
            K_CNT:   return {26'd0, busy_count};
            K_SPEC:  return {31'd0, spec_any};
            K_RBUSY: return {30'd0, rd_busy};
            default: return {28'd0, rd_tag};
        endcase
    endfunction

    // Monitor: compare every expectation whose cycle has come
    always @(negedge CLK) begin
        int i;
        logic [31:0] got;
        i = 0;
        while (i < sb_q.size()) begin
            if (sb_q[i].cyc <= cyc) begin
                got = observe(sb_q[i].kind);
                n_chk++;
                if (got !== sb_q[i].val) begin
                    n_fail++;
                    $display("FAIL %s cyc=%0d got=%h want=%h", kname(sb_q[i].kind), cyc, got, sb_q[i].val);
                end
                sb_q.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic expect_at(input int at, input int kind, input logic [31:0] val);
        exp_t e;
        e.cyc = at;
        e.kind = kind;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
        di_write = 1'b0; di_sel = '0; di_tag = '0; di_spec_mask = '0;
        wb_write = '0; wb_sel = '0; wb_tag = '0;
        resolve_mask = '0; flush_mask = '0; rd_sel = '0;
    endtask

    task automatic dispatch(input logic [4:0] s, input logic [1:0] t, input logic [3:0] m);
        di_write = 1'b1; di_sel = s; di_tag = t; di_spec_mask = m;
    endtask

    task automatic set_wb(input int p, input logic [4:0] s, input logic [1:0] t);
        wb_write[p] = 1'b1;
        wb_sel[p*SEL_W +: SEL_W] = s;
        wb_tag[p*TAG_W +: TAG_W] = t;
    endtask

    initial begin
        int budget;
        nRST = 1'b0;
        di_write = 1'b0; di_sel = '0; di_tag = '0; di_spec_mask = '0;
        wb_write = '0; wb_sel = '0; wb_tag = '0;
        resolve_mask = '0; flush_mask = '0; rd_sel = '0;

        // Reset state
        step();
        expect_at(cyc, K_VEC, 0);
        expect_at(cyc, K_CNT, 0);
        expect_at(cyc, K_SPEC, 0);
        expect_at(cyc, K_RBUSY, 0);
        expect_at(cyc, K_RTAG, 0);
        step();
        nRST = 1'b1;

        // Basic dispatch, lookup, forwarded writeback
        step(); dispatch(3, 2, 4'b0000);
        step(); rd_sel[4:0] = 3;
        expect_at(cyc, K_RBUSY, 32'h1);
        expect_at(cyc, K_RTAG, 32'h2);
        expect_at(cyc, K_VEC, 32'h8);
        expect_at(cyc, K_CNT, 1);
        step(); rd_sel[4:0] = 3; set_wb(1, 3, 2);
        expect_at(cyc, K_RBUSY, 0);
        expect_at(cyc, K_RTAG, 0);
        expect_at(cyc + 1, K_VEC, 0);
        expect_at(cyc + 1, K_CNT, 0);

        // Stale writeback ignored, matching one clears
        step(); dispatch(5, 1, 4'b0000);
        step(); set_wb(0, 5, 3); rd_sel[4:0] = 5;
        expect_at(cyc, K_RBUSY, 32'h1);
        expect_at(cyc, K_RTAG, 32'h1);
        expect_at(cyc + 1, K_VEC, 32'h20);
        expect_at(cyc + 1, K_CNT, 1);
        step(); set_wb(0, 5, 1); rd_sel[4:0] = 5;
        expect_at(cyc, K_RBUSY, 0);
        expect_at(cyc + 1, K_VEC, 0);
        expect_at(cyc + 1, K_CNT, 0);

        // Per-level flush and resolve
        step(); dispatch(4, 0, 4'b0001);
        step(); dispatch(6, 1, 4'b0010);
        expect_at(cyc, K_SPEC, 1);
        step(); dispatch(7, 3, 4'b0000);
        expect_at(cyc, K_CNT, 2);
        step(); flush_mask = 4'b0010;
        expect_at(cyc, K_VEC, 32'hD0);
        expect_at(cyc, K_CNT, 3);
        expect_at(cyc + 1, K_VEC, 32'h90);
        expect_at(cyc + 1, K_CNT, 2);
        expect_at(cyc + 1, K_SPEC, 1);
        step(); resolve_mask = 4'b0001;
        expect_at(cyc + 1, K_VEC, 32'h90);
        expect_at(cyc + 1, K_SPEC, 0);
        step(); flush_mask = 4'b0001; rd_sel[4:0] = 4; rd_sel[9:5] = 7;
        expect_at(cyc, K_RBUSY, 32'h3);
        expect_at(cyc, K_RTAG, 32'hC);
        expect_at(cyc + 1, K_VEC, 32'h90);
        step(); set_wb(0, 4, 0); set_wb(1, 7, 3); rd_sel[4:0] = 4; rd_sel[9:5] = 7;
        expect_at(cyc, K_RBUSY, 0);
        expect_at(cyc, K_RTAG, 0);
        expect_at(cyc + 1, K_VEC, 0);
        expect_at(cyc + 1, K_CNT, 0);

        // Dispatch on a flushed level is dropped
        step(); dispatch(8, 1, 4'b0100); flush_mask = 4'b0100;
        expect_at(cyc + 1, K_VEC, 0);
        expect_at(cyc + 1, K_CNT, 0);

        // Dispatch beats same-cycle writeback
        step(); dispatch(9, 1, 4'b0000);
        step(); dispatch(9, 2, 4'b0000); set_wb(0, 9, 1); rd_sel[4:0] = 9;
        expect_at(cyc, K_RBUSY, 0);
        expect_at(cyc + 1, K_VEC, 32'h200);
        expect_at(cyc + 1, K_CNT, 1);
        step(); rd_sel[4:0] = 9;
        expect_at(cyc, K_RBUSY, 32'h1);
        expect_at(cyc, K_RTAG, 32'h2);
        step(); set_wb(1, 9, 2);
        expect_at(cyc + 1, K_VEC, 0);

        // Resolve and flush on the same level behaves as flush
        step(); dispatch(10, 1, 4'b0010);
        step(); resolve_mask = 4'b0010; flush_mask = 4'b0010;
        expect_at(cyc, K_VEC, 32'h400);
        expect_at(cyc, K_SPEC, 1);
        expect_at(cyc + 1, K_VEC, 0);
        expect_at(cyc + 1, K_SPEC, 0);
        expect_at(cyc + 1, K_CNT, 0);

        // Same-cycle resolve trims the dispatched mask
        step(); dispatch(12, 0, 4'b0011); resolve_mask = 4'b0001;
        step(); flush_mask = 4'b0001;
        expect_at(cyc + 1, K_VEC, 32'h1000);
        expect_at(cyc + 1, K_SPEC, 1);
        step(); flush_mask = 4'b0010;
        expect_at(cyc + 1, K_VEC, 0);
        expect_at(cyc + 1, K_SPEC, 0);

        // Zero register never busy
        step(); dispatch(0, 3, 4'b0000);
        step();
        expect_at(cyc, K_RBUSY, 0);
        expect_at(cyc, K_VEC, 0);
        expect_at(cyc, K_CNT, 0);

        // Both writeback ports hitting one register
        step(); dispatch(2, 1, 4'b0000);
        step(); set_wb(0, 2, 1); set_wb(1, 2, 1); rd_sel[9:5] = 2;
        expect_at(cyc, K_VEC, 32'h4);
        expect_at(cyc, K_RBUSY, 0);
        expect_at(cyc + 1, K_VEC, 0);
        expect_at(cyc + 1, K_CNT, 0);

        // Asynchronous reset with five busy registers
        step(); dispatch(1, 1, 4'b0000);
        step(); dispatch(2, 2, 4'b0000);
        step(); dispatch(3, 3, 4'b1000);
        step(); dispatch(4, 0, 4'b0000);
        step(); dispatch(5, 1, 4'b0000);
        step(); rd_sel[4:0] = 3;
        expect_at(cyc, K_CNT, 5);
        expect_at(cyc, K_VEC, 32'h3E);
        expect_at(cyc, K_SPEC, 1);
        expect_at(cyc, K_RBUSY, 32'h1);
        step(); rd_sel[4:0] = 3;
        #1 nRST = 1'b0;
        expect_at(cyc, K_VEC, 0);
        expect_at(cyc, K_CNT, 0);
        expect_at(cyc, K_SPEC, 0);
        expect_at(cyc, K_RBUSY, 0);
        expect_at(cyc, K_RTAG, 0);
        step();
        step(); nRST = 1'b1; rd_sel[4:0] = 3;
        expect_at(cyc + 1, K_VEC, 0);
        expect_at(cyc + 1, K_CNT, 0);

        // Drain the scoreboard within a bounded number of cycles
        budget = 0;
        while (sb_q.size() != 0 && budget < 20) begin
            step();
            budget++;
        end
        if (sb_q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain pending=%0d want=0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
